// File: rtl/icache_dm_if.sv
// icache_dm_if: AXI-Lite read address/data channel bundle
interface icache_dm_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  modport master(output araddr, arvalid, rready, input arready, rvalid, rdata, rresp);
  modport slave(input araddr, arvalid, rready, output arready, rvalid, rdata, rresp);
endinterface

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache with line refill and fence.i flush
module icache_dm #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  icache_dm_if.slave  s,
  icache_dm_if.master m,
  input  logic        is_fence_i,
  output logic        icache_flush_done,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);
  localparam int OFF_W = $clog2(WORDS * 4);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 32 - OFF_W - IDX_W;
  localparam int WRD_W = $clog2(WORDS);
  localparam logic [2:0] IDLE = 3'd0, LOOKUP = 3'd1, REFILL_AR = 3'd2, REFILL_R = 3'd3, RESP = 3'd4, FLUSH = 3'd5;
  logic [2:0]       r_state;
  logic [31:2]      r_addr;
  logic [WRD_W-1:0] r_beat;
  logic [IDX_W-1:0] r_fcnt;
  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [LINES];
  logic [31:0]      r_data [LINES*WORDS];
  logic             r_err, r_rvalid, r_arvalid, r_rready, r_done;
  logic [31:0]      r_rdata, r_hit, r_miss;
  logic [1:0]       r_rresp;
  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_idx;
  logic [WRD_W-1:0] w_word;
  logic             w_hit, w_beat_hs, w_last, w_err;
  logic [31:0]      w_word_data;
  assign w_tag       = r_addr[31:OFF_W+IDX_W];
  assign w_idx       = r_addr[OFF_W+IDX_W-1:OFF_W];
  assign w_word      = r_addr[OFF_W-1:2];
  assign w_hit       = r_valid[w_idx] && r_tag[w_idx] == w_tag;
  assign w_beat_hs   = r_state == REFILL_R && m.rvalid && !reset;
  assign w_last      = r_beat == WRD_W'(WORDS - 1);
  assign w_err       = r_err || m.rresp != 2'b00;
  // the requested word may be arriving on the final beat, not yet in the array
  assign w_word_data = w_word == r_beat ? m.rdata : r_data[{w_idx, w_word}];
  assign s.arready   = r_state == IDLE && !is_fence_i;
  assign s.rvalid    = r_rvalid;
  assign s.rdata     = r_rdata;
  assign s.rresp     = r_rresp;
  assign m.araddr    = {r_addr[31:OFF_W], r_beat, 2'b00};
  assign m.arvalid   = r_arvalid;
  assign m.rready    = r_rready;
  assign icache_flush_done = r_done;
  assign hit_cnt     = r_hit;
  assign miss_cnt    = r_miss;
  // data and tag arrays are not reset; validity alone governs hits
  always_ff @(posedge clk) begin
    if (w_beat_hs) r_data[{w_idx, r_beat}] <= m.rdata;
    if (w_beat_hs && w_last && !w_err) r_tag[w_idx] <= w_tag;
  end
  // control FSM: lookup, refill beats, response hold and flush walk
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_beat    <= '0;
      r_fcnt    <= '0;
      r_valid   <= '0;
      r_err     <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_done    <= 1'b0;
      r_hit     <= '0;
      r_miss    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE:
          if (is_fence_i) begin
            r_fcnt  <= '0;
            r_state <= FLUSH;
          end else if (s.arvalid) begin
            r_addr  <= s.araddr[31:2];
            r_state <= LOOKUP;
          end
        LOOKUP:
          if (w_hit) begin
            r_rdata  <= r_data[{w_idx, w_word}];
            r_rresp  <= 2'b00;
            r_rvalid <= 1'b1;
            if (r_hit != '1) r_hit <= r_hit + 32'd1;
            r_state  <= RESP;
          end else begin
            if (r_miss != '1) r_miss <= r_miss + 32'd1;
            r_valid[w_idx] <= 1'b0;
            r_beat    <= '0;
            r_err     <= 1'b0;
            r_arvalid <= 1'b1;
            r_state   <= REFILL_AR;
          end
        REFILL_AR:
          if (m.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= REFILL_R;
          end
        REFILL_R:
          if (m.rvalid) begin
            r_rready <= 1'b0;
            r_err    <= w_err;
            if (w_last) begin
              r_valid[w_idx] <= !w_err;
              r_rdata  <= w_err ? 32'd0 : w_word_data;
              r_rresp  <= w_err ? 2'b10 : 2'b00;
              r_rvalid <= 1'b1;
              r_state  <= RESP;
            end else begin
              r_beat    <= r_beat + 1'b1;
              r_arvalid <= 1'b1;
              r_state   <= REFILL_AR;
            end
          end
        RESP:
          if (s.rready) begin
            r_rvalid <= 1'b0;
            r_state  <= IDLE;
          end
        FLUSH: begin
          r_valid[r_fcnt] <= 1'b0;
          r_fcnt <= r_fcnt + 1'b1;
          if (r_fcnt == IDX_W'(LINES - 1)) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: randomized check of icache_dm against a line-level cache model
module tb_icache_dm;
  localparam int LINES = 16;
  localparam int WORDS = 4;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        is_fence_i = 1'b0;
  logic        icache_flush_done;
  logic [31:0] hit_cnt, miss_cnt;
  icache_dm_if s();
  icache_dm_if m();
  icache_dm #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clk(clk), .reset(reset), .s(s), .m(m), .is_fence_i(is_fence_i),
    .icache_flush_done(icache_flush_done), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );
  always #5 clk = ~clk;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          mv [LINES];
  logic [31:0] mt [LINES];
  int          e_hit = 0;
  int          e_miss = 0;
  logic [31:0] err_addr = '1;
  logic [31:0] ar_log [$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [31:0] k;
    k = {28'd0, 2'b00, a[3:2]} + 32'd1;
    if (a[31:4] == 28'h3000000) return 32'h11 * k;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bit pend, rdone;
    int dly;
    logic [31:0] paddr;
    pend = 0; rdone = 0; dly = 0; paddr = '0;
    m.arready = 1'b0; m.rvalid = 1'b0; m.rdata = '0; m.rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (reset) begin
        m.arready = 1'b0; m.rvalid = 1'b0; pend = 0; rdone = 0;
      end else begin
        if (rdone) begin
          m.rvalid = 1'b0; pend = 0; rdone = 0;
        end
        if (pend && !m.rvalid) begin
          if (dly == 0) begin
            m.rvalid = 1'b1;
            m.rdata  = mem(paddr);
            m.rresp  = paddr == err_addr ? 2'b10 : 2'b00;
          end else dly--;
        end
        m.arready = !pend && ($urandom_range(0, 2) != 0);
        if (m.arvalid && m.arready) begin
          pend = 1; paddr = m.araddr; dly = $urandom_range(0, 3);
          ar_log.push_back(m.araddr);
        end
        if (m.rvalid && m.rready) rdone = 1;
      end
    end
  end
  task automatic do_reset();
    reset = 1'b1;
    cyc();
    check("rst_rvalid", 32'(s.rvalid), 0);
    check("rst_rdata", s.rdata, 0);
    check("rst_rresp", 32'(s.rresp), 0);
    check("rst_arvalid", 32'(m.arvalid), 0);
    check("rst_rready", 32'(m.rready), 0);
    check("rst_done", 32'(icache_flush_done), 0);
    check("rst_hit", hit_cnt, 0);
    check("rst_miss", miss_cnt, 0);
    reset = 1'b0;
    for (int i = 0; i < LINES; i++) mv[i] = 0;
    e_hit = 0; e_miss = 0;
    ar_log.delete();
  endtask
  task automatic issue(input logic [31:0] a, output bit ok);
    s.araddr = a; s.arvalid = 1'b1; ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = s.arready;
      cyc();
    end
    s.arvalid = 1'b0;
    check("ar_accept", 32'(ok), 1);
  endtask
  task automatic fetch(input logic [31:0] a, input int bp);
    logic [31:0] w, base, tag, ed;
    int idx, n;
    bit hit, err, ok;
    w = a & ~32'h3; base = a & ~32'hF;
    idx = int'((w / 16) % LINES); tag = w / (16 * LINES);
    hit = mv[idx] && mt[idx] == tag; err = 0;
    ar_log.delete();
    issue(a, ok);
    if (!ok) return;
    n = 0;
    while (!s.rvalid && n < 200) begin cyc(); n++; end
    check("rvalid_seen", 32'(s.rvalid), 1);
    if (hit) begin
      e_hit++;
      check("hit_latency", 32'(n), 1);
      check("hit_no_ar", 32'(ar_log.size()), 0);
    end else begin
      e_miss++;
      check("miss_beats", 32'(ar_log.size()), WORDS);
      for (int k = 0; k < WORDS; k++) begin
        if (k < ar_log.size()) check("beat_addr", ar_log[k], base + 32'(4 * k));
        if (base + 32'(4 * k) == err_addr) err = 1;
      end
      mv[idx] = !err; mt[idx] = tag;
    end
    ed = err ? 32'd0 : mem(w);
    for (int i = 0; i <= bp; i++) begin
      check("rdata", s.rdata, ed);
      check("rresp", 32'(s.rresp), err ? 32'd2 : 32'd0);
      check("rvalid_hold", 32'(s.rvalid), 1);
      if (i < bp) cyc();
    end
    s.rready = 1'b1;
    cyc();
    s.rready = 1'b0;
    check("rvalid_drop", 32'(s.rvalid), 0);
    check("hit_cnt", hit_cnt, 32'(e_hit));
    check("miss_cnt", miss_cnt, 32'(e_miss));
  endtask
  task automatic flush();
    is_fence_i = 1'b1;
    cyc();
    is_fence_i = 1'b0;
    check("flush_arready", 32'(s.arready), 0);
    for (int i = 1; i <= LINES; i++) begin
      cyc();
      check("flush_done", 32'(icache_flush_done), i == LINES ? 32'd1 : 32'd0);
      if (i < LINES) check("flush_arready", 32'(s.arready), 0);
    end
    cyc();
    check("flush_done_pulse", 32'(icache_flush_done), 0);
    for (int i = 0; i < LINES; i++) mv[i] = 0;
  endtask
  function automatic logic [31:0] rand_addr();
    logic [31:0] t;
    case ($urandom_range(0, 2))
      0: t = 32'h300000;
      1: t = 32'h300001;
      default: t = 32'hABCDE5;
    endcase
    return (t << 8) | (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
  endfunction
  initial begin
    bit ok;
    int n;
    s.araddr = '0; s.arvalid = 1'b0; s.rready = 1'b0;
    cyc();
    do_reset();
    fetch(32'h30000004, 0);
    fetch(32'h3000000C, 0);
    fetch(32'h30000100, 0);
    fetch(32'h30000000, 0);
    flush();
    fetch(32'h30000000, 0);
    err_addr = 32'h30000208;
    fetch(32'h30000204, 0);
    err_addr = '1;
    fetch(32'h30000204, 0);
    fetch(32'h3000020C, 5);
    issue(32'h30000040, ok);
    n = 0;
    while (!m.rready && n < 100) begin cyc(); n++; end
    check("refill_r_seen", 32'(m.rready), 1);
    do_reset();
    fetch(32'h30000040, 0);
    for (int t = 0; t < 250; t++) begin
      case ($urandom_range(0, 19))
        0: flush();
        1: err_addr = rand_addr() & ~32'h3;
        2: err_addr = '1;
        default: fetch(rand_addr(), $urandom_range(0, 3) == 0 ? $urandom_range(1, 4) : 0);
      endcase
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
  initial begin
    #600000;
    $display("FAIL watchdog checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1);
  end
endmodule
